dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port byte-addressed data memory. Requester 0 is the core load/store path; requester 1 is the program/debug loader. Each access is accepted through a valid/ready handshake and driven onto the memory port for exactly one cycle. The read result, or an error, is returned as a one-cycle response pulse to the requester that owns the access.

---
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester arbiter and sequencer for the single-port,
//            byte-addressed data memory. Requester 0 is the core load/store
//            path, requester 1 the program/debug loader. One access is
//            accepted through valid/ready, driven onto the memory port for
//            exactly one cycle, and answered with a one-cycle response pulse
//            (read data or range error) to the requester that owns it.
//            Fixed latency: accept N, memory access N+1, response N+2.
// Ports    : clock      - system clock, rising edge
//            reset      - asynchronous, active-low reset
//            req_valid  - [i] requester i has a pending access
//            req_ready  - [i] requester i accepted this cycle (combinational)
//            req_we     - [i] 1 = store, 0 = load
//            req_size   - [3i+:3] access type code
//            req_addr   - [32i+:32] byte address
//            req_wdata  - [32i+:32] store data
//            rsp_valid  - [i] one-cycle response pulse to requester i
//            rsp_err    - response qualifier: access was out of range
//            rsp_rdata  - load data (0 for stores and errors)
//            mem_addr/mem_wdata/mem_size/mem_wr - memory port
//            mem_rdata  - combinational read data from memory
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_BYTES  = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [5:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_size,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    // Access type codes
    localparam logic [2:0] c_LB_SB = 3'd0;
    localparam logic [2:0] c_LH_SH = 3'd1;
    localparam logic [2:0] c_LW_SW = 3'd2;
    localparam logic [2:0] c_LBU   = 3'd4;
    localparam logic [2:0] c_LHU   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_rr_ptr;
    logic        r_gid;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_gid;
    logic        w_accept;
    logic        w_sel_we;
    logic [2:0]  w_sel_size;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [32:0] w_bytes;
    logic [32:0] w_end;
    logic        w_err;

    // ------------------------------------------------------------------
    // Arbitration and range check of the request that would be accepted
    // ------------------------------------------------------------------
    always_comb begin
        w_gid = 1'b0;
        case (req_valid)
            2'b10:   w_gid = 1'b1;
            2'b11:   w_gid = (FIXED_PRIO != 0) ? 1'b0 : r_rr_ptr;
            default: w_gid = 1'b0;
        endcase

        // reset gates ready so that outputs are idle while reset is held
        w_accept    = (r_state == S_IDLE) && (|req_valid) && reset;

        w_sel_we    = w_gid ? req_we[1]          : req_we[0];
        w_sel_size  = w_gid ? req_size[5:3]      : req_size[2:0];
        w_sel_addr  = w_gid ? req_addr[63:32]    : req_addr[31:0];
        w_sel_wdata = w_gid ? req_wdata[63:32]   : req_wdata[31:0];

        case (w_sel_size)
            c_LB_SB, c_LBU: w_bytes = 33'd1;
            c_LH_SH, c_LHU: w_bytes = 33'd2;
            c_LW_SW:        w_bytes = 33'd4;
            default:        w_bytes = 33'd1;
        endcase

        // 33-bit sum: an address near the top of the space cannot wrap
        w_end = {1'b0, w_sel_addr} + w_bytes;
        w_err = (w_end > 33'(MEM_BYTES));
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        rsp_err     = 1'b0;
        rsp_rdata   = 32'd0;
        mem_wr      = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        mem_size    = c_LW_SW;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    req_ready   = w_gid ? 2'b10 : 2'b01;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_addr    = r_addr;
                mem_wdata   = r_wdata;
                mem_size    = r_size;
                mem_wr      = r_we & ~r_err;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid   = r_gid ? 2'b10 : 2'b01;
                rsp_err     = r_err;
                rsp_rdata   = r_rdata;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched access, round-robin pointer and read data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= 1'b0;
            r_gid    <= 1'b0;
            r_we     <= 1'b0;
            r_size   <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_gid    <= w_gid;
                r_we     <= w_sel_we;
                r_size   <= w_sel_size;
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
                r_err    <= w_err;
                // pointer always ends up on the requester that lost
                r_rr_ptr <= ~w_gid;
            end
            if (r_state == S_ACCESS) begin
                r_rdata <= (!r_we && !r_err) ? mem_rdata : 32'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. Two instances run side by
//            side (index 0: round-robin, index 1: fixed priority), each with
//            its own requesters and a behavioural reference model that is
//            compared against every output on every falling clock edge.
//            Directed scenarios pin literal values, then random traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam logic [2:0] c_LB_SB = 3'd0;
    localparam logic [2:0] c_LH_SH = 3'd1;
    localparam logic [2:0] c_LW_SW = 3'd2;
    localparam logic [2:0] c_LBU   = 3'd4;
    localparam logic [2:0] c_LHU   = 3'd5;
    localparam int         c_MEM   = 32;

    logic        clock;
    logic        reset;
    logic [1:0]  req_valid [2];
    logic [1:0]  req_ready [2];
    logic [1:0]  req_we    [2];
    logic [5:0]  req_size  [2];
    logic [63:0] req_addr  [2];
    logic [63:0] req_wdata [2];
    logic [1:0]  rsp_valid [2];
    logic        rsp_err   [2];
    logic [31:0] rsp_rdata [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [2:0]  mem_size  [2];
    logic        mem_wr    [2];
    logic [31:0] mem_rdata [2];

    int n_vec = 0;
    int n_err = 0;

    // memory contents as a pure function of address
    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'd4) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter #(.MEM_BYTES(c_MEM), .FIXED_PRIO(g)) u_dut (
            .clock     (clock),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_size  (req_size[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_err   (rsp_err[g]),
            .rsp_rdata (rsp_rdata[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_size  (mem_size[g]),
            .mem_wr    (mem_wr[g]),
            .mem_rdata (mem_rdata[g])
        );
        assign mem_rdata[g] = memfn(mem_addr[g]);
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase 0 = free, 1 = memory cycle, 2 = response
    // ------------------------------------------------------------------
    int          m_phase [2];
    int          m_last  [2];
    int          m_id    [2];
    logic        m_we    [2];
    logic [2:0]  m_size  [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        m_err   [2];
    logic [31:0] m_rdata [2];

    function automatic int nbytes(input logic [2:0] s);
        case (s)
            c_LH_SH, c_LHU: return 2;
            c_LW_SW:        return 4;
            default:        return 1;
        endcase
    endfunction

    // who wins among the currently valid requesters (-1 = nobody)
    function automatic int pick(input int k);
        if (req_valid[k] == 2'b01) return 0;
        if (req_valid[k] == 2'b10) return 1;
        if (req_valid[k] == 2'b11) return (k == 1) ? 0 : ((m_last[k] == 0) ? 1 : 0);
        return -1;
    endfunction

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            int          g;
            longint      ea;
            logic [1:0]  e_ready;
            logic [34:0] e_rsp;
            logic [67:0] e_mem;
            if (!reset) begin
                m_phase[k] = 0;
                m_last[k]  = 1;
            end
            g       = pick(k);
            e_ready = 2'b00;
            e_rsp   = '0;
            e_mem   = {1'b0, 32'd0, 32'd0, c_LW_SW};
            if (m_phase[k] == 0 && reset && g >= 0) e_ready = (g == 1) ? 2'b10 : 2'b01;
            if (m_phase[k] == 1) e_mem = {m_we[k] & ~m_err[k], m_addr[k], m_wdata[k], m_size[k]};
            if (m_phase[k] == 2) e_rsp = {(m_id[k] == 1) ? 2'b10 : 2'b01, m_err[k], m_rdata[k]};
            chk($sformatf("ready[%0d]", k), 128'(req_ready[k]), 128'(e_ready));
            chk($sformatf("rsp[%0d]", k), 128'({rsp_valid[k], rsp_err[k], rsp_rdata[k]}), 128'(e_rsp));
            chk($sformatf("mem[%0d]", k),
                128'({mem_wr[k], mem_addr[k], mem_wdata[k], mem_size[k]}), 128'(e_mem));
            if (reset) begin
                case (m_phase[k])
                    0: if (g >= 0) begin
                        m_id[k]    = g;
                        m_we[k]    = req_we[k][g];
                        m_size[k]  = req_size[k][3*g +: 3];
                        m_addr[k]  = req_addr[k][32*g +: 32];
                        m_wdata[k] = req_wdata[k][32*g +: 32];
                        ea         = longint'({32'd0, m_addr[k]}) + nbytes(m_size[k]);
                        m_err[k]   = (ea > c_MEM);
                        m_last[k]  = g;
                        m_phase[k] = 1;
                    end
                    1: begin
                        m_rdata[k] = (!m_we[k] && !m_err[k]) ? memfn(m_addr[k]) : 32'd0;
                        m_phase[k] = 2;
                    end
                    default: m_phase[k] = 0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_req(input int k, input int i, input logic v, input logic we,
                           input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        req_valid[k][i]         = v;
        req_we[k][i]            = we;
        req_size[k][3*i +: 3]   = sz;
        req_addr[k][32*i +: 32] = a;
        req_wdata[k][32*i +: 32] = d;
    endtask

    task automatic junk(input int k, input int i);
        set_req(k, i, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
    endtask

    task automatic rand_req(input int k, input int i);
        logic [2:0]  sz;
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0:       sz = c_LB_SB;
            1:       sz = c_LH_SH;
            2:       sz = c_LW_SW;
            3:       sz = c_LBU;
            4:       sz = c_LHU;
            default: sz = 3'($urandom);
        endcase
        if ($urandom_range(0, 15) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        else                            a = 32'($urandom_range(0, 40));
        set_req(k, i, 1'b1, 1'($urandom), sz, a, $urandom);
    endtask

    task automatic pos1();
        @(posedge clock);
        #1;
    endtask

    int         gcyc [2][8];
    int         gid  [2][8];
    int         ng   [2];
    logic [1:0] rdy  [2];

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = '0; req_we[k] = '0; req_size[k] = '0;
            req_addr[k]  = '0; req_wdata[k] = '0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // single load, requester 0, LW at 4
        for (int k = 0; k < 2; k++) set_req(k, 0, 1'b1, 1'b0, c_LW_SW, 32'd4, 32'd0);
        @(negedge clock);
        for (int k = 0; k < 2; k++) chk("t1_ready", 128'(req_ready[k]), 128'(2'b01));
        pos1();
        for (int k = 0; k < 2; k++) junk(k, 0);
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            chk("t1_mem_wr", 128'(mem_wr[k]), 128'(1'b0));
            chk("t1_mem_addr", 128'(mem_addr[k]), 128'(32'd4));
        end
        @(negedge clock);
        for (int k = 0; k < 2; k++)
            chk("t1_rsp", 128'({rsp_valid[k], rsp_err[k], rsp_rdata[k]}), 128'({2'b01, 1'b0, 32'hDEADBEEF}));
        pos1();

        // single store, requester 1, LH at 8
        for (int k = 0; k < 2; k++) set_req(k, 1, 1'b1, 1'b1, c_LH_SH, 32'd8, 32'h1234ABCD);
        @(negedge clock);
        for (int k = 0; k < 2; k++) chk("t2_ready", 128'(req_ready[k]), 128'(2'b10));
        pos1();
        for (int k = 0; k < 2; k++) junk(k, 1);
        @(negedge clock);
        for (int k = 0; k < 2; k++)
            chk("t2_mem", 128'({mem_wr[k], mem_addr[k], mem_size[k], mem_wdata[k]}),
                128'({1'b1, 32'd8, c_LH_SH, 32'h1234ABCD}));
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            chk("t2_wr_drop", 128'(mem_wr[k]), 128'(1'b0));
            chk("t2_rsp", 128'({rsp_valid[k], rsp_err[k], rsp_rdata[k]}), 128'({2'b10, 1'b0, 32'd0}));
        end
        pos1();

        // contention: both held for 12 cycles
        for (int k = 0; k < 2; k++) begin
            set_req(k, 0, 1'b1, 1'b0, c_LW_SW, 32'd0, 32'd0);
            set_req(k, 1, 1'b1, 1'b0, c_LBU, 32'd5, 32'd0);
            ng[k] = 0;
            for (int j = 0; j < 8; j++) begin gcyc[k][j] = -1; gid[k][j] = -1; end
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++)
                if (req_ready[k] != 2'b00 && ng[k] < 8) begin
                    gcyc[k][ng[k]] = c;
                    gid[k][ng[k]]  = req_ready[k][1] ? 1 : 0;
                    ng[k]++;
                end
            pos1();
        end
        for (int k = 0; k < 2; k++) begin
            chk("t3_ngrant", 128'(ng[k]), 128'(4));
            for (int j = 0; j < 4; j++) begin
                chk("t3_cycle", 128'(gcyc[k][j]), 128'(3 * j));
                chk("t3_id", 128'(gid[k][j]), 128'((k == 0) ? (j % 2) : 0));
            end
            junk(k, 0);
        end
        @(negedge clock);
        for (int k = 0; k < 2; k++) chk("t3_after_drop", 128'(req_ready[k]), 128'(2'b10));
        pos1();
        for (int k = 0; k < 2; k++) junk(k, 1);
        repeat (2) pos1();

        // range error store, then last-byte load
        for (int k = 0; k < 2; k++) set_req(k, 0, 1'b1, 1'b1, c_LW_SW, 32'd30, 32'hCAFEF00D);
        @(negedge clock);
        for (int k = 0; k < 2; k++) chk("t5_ready", 128'(req_ready[k]), 128'(2'b01));
        pos1();
        for (int k = 0; k < 2; k++) junk(k, 0);
        @(negedge clock);
        for (int k = 0; k < 2; k++) chk("t5_mem_wr", 128'(mem_wr[k]), 128'(1'b0));
        @(negedge clock);
        for (int k = 0; k < 2; k++)
            chk("t5_rsp", 128'({rsp_valid[k], rsp_err[k], rsp_rdata[k]}), 128'({2'b01, 1'b1, 32'd0}));
        pos1();
        for (int k = 0; k < 2; k++) set_req(k, 0, 1'b1, 1'b0, c_LB_SB, 32'd31, 32'd0);
        @(negedge clock);
        pos1();
        for (int k = 0; k < 2; k++) junk(k, 0);
        repeat (2) @(negedge clock);
        for (int k = 0; k < 2; k++)
            chk("t5_lb31", 128'({rsp_valid[k], rsp_err[k]}), 128'({2'b01, 1'b0}));
        pos1();

        // reset during the memory cycle of a store
        for (int k = 0; k < 2; k++) set_req(k, 0, 1'b1, 1'b1, c_LW_SW, 32'd12, 32'hA5A5A5A5);
        @(negedge clock);
        pos1();
        for (int k = 0; k < 2; k++) junk(k, 0);
        #1;
        for (int k = 0; k < 2; k++) chk("t6_wr_before", 128'(mem_wr[k]), 128'(1'b1));
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t6_idle_outs",
                128'({req_ready[k], rsp_valid[k], rsp_err[k], rsp_rdata[k], mem_wr[k], mem_addr[k], mem_wdata[k], mem_size[k]}),
                128'({2'b00, 2'b00, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, c_LW_SW}));
            set_req(k, 0, 1'b1, 1'b0, c_LW_SW, 32'd0, 32'd0);
            set_req(k, 1, 1'b1, 1'b0, c_LW_SW, 32'd16, 32'd0);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 2; k++) chk("t6_first_win", 128'(req_ready[k]), 128'(2'b01));
        pos1();
        for (int k = 0; k < 2; k++) junk(k, 0);

        // random traffic with withdrawals and out-of-range accesses
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) rdy[k] = req_ready[k];
            pos1();
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 2; i++) begin
                    if (req_valid[k][i]) begin
                        if (rdy[k][i]) begin
                            if ($urandom_range(0, 1) == 0) rand_req(k, i);
                            else                           junk(k, i);
                        end else if ($urandom_range(0, 15) == 0) begin
                            junk(k, i);
                        end
                    end else if ($urandom_range(0, 2) == 0) begin
                        rand_req(k, i);
                    end
                end
        end

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
